// File: rtl/rap_pkg.sv
// ---------------------------------------------------------------------------
// rap_pkg -- shared definitions for the approximate-adder error monitor.
//   state_t       : 2-bit FSM state encoding (IDLE, RUN, DRAIN, REPORT)
//   OP_W          : operand width of the monitored adder
//   SUM_W         : width of the exact / approximate sum (OP_W + 1)
//   WIN_LOG2_DEF  : default log2 of samples per measurement window
//   abs_diff      : unsigned absolute difference of two SUM_W values
// ---------------------------------------------------------------------------
package rap_pkg;

    localparam int OP_W         = 8;
    localparam int SUM_W        = OP_W + 1;
    localparam int WIN_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] x,
                                                  input logic [SUM_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/rap_ed_calc.sv
// ---------------------------------------------------------------------------
// rap_ed_calc -- combinational error-distance calculator.
// Forms the exact 9-bit sum a+b and compares it with the approximate adder's
// result.
//   a, b       in  : 8-bit operands
//   approx_sum in  : 9-bit approximate sum for the same operands
//   ed         out : |exact - approx_sum|
//   mismatch   out : 1 when approx_sum differs from the exact sum
// ---------------------------------------------------------------------------
module rap_ed_calc
    import rap_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [SUM_W-1:0] approx_sum,
    output logic [SUM_W-1:0] ed,
    output logic             mismatch
);

    logic [SUM_W-1:0] exact;

    // Zero-extend before adding so the carry lands in bit 8.
    assign exact = {1'b0, a} + {1'b0, b};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block leaves a value held (no latch).
        ed       = '0;
        mismatch = 1'b0;
        ed       = abs_diff(exact, approx_sum);
        mismatch = (exact != approx_sum);
    end

endmodule

// File: rtl/rap_err_mon.sv
// ---------------------------------------------------------------------------
// rap_err_mon -- windowed error monitor for an 8-bit approximate adder.
// After start, accepts 2^WIN_LOG2 samples (a, b, approx_sum), registers each
// sample's error distance into a one-entry stage s1, and accumulates the
// mismatch count, maximum and total error distance. One DRAIN cycle folds in
// the last s1 entry, then the report is held until rpt_ready.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a window (IDLE only)
//   in_valid/in_ready : sample handshake (in_ready high only in RUN)
//   a, b, approx_sum  : sample operands and approximate result
//   busy              : high in any state but IDLE
//   rpt_valid/ready   : report handshake
//   err_cnt, max_ed, sum_ed : window statistics, held until next start
// ---------------------------------------------------------------------------
module rap_err_mon
    import rap_pkg::*;
#(
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       a,
    input  logic [OP_W-1:0]       b,
    input  logic [SUM_W-1:0]      approx_sum,
    output logic                  busy,
    output logic                  rpt_valid,
    input  logic                  rpt_ready,
    output logic [WIN_LOG2:0]     err_cnt,
    output logic [SUM_W-1:0]      max_ed,
    output logic [SUM_W+WIN_LOG2-1:0] sum_ed
);

    localparam int CNT_W = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << WIN_LOG2) - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1_vld;
    logic [SUM_W-1:0] s1_ed;
    logic             s1_flag;

    logic [SUM_W-1:0] ed;
    logic             mismatch;
    logic             accept;

    rap_ed_calc u_ed_calc (
        .a          (a),
        .b          (b),
        .approx_sum (approx_sum),
        .ed         (ed),
        .mismatch   (mismatch)
    );

    assign accept = in_valid && in_ready && (state == ST_RUN);

    // NOTE: all state below uses non-blocking assignments, so every right-hand
    // side reads the pre-edge value; where two assignments to the same
    // register fire on one edge, the later one in this block wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            rpt_valid <= 1'b0;
            cnt       <= '0;
            s1_vld    <= 1'b0;
            s1_ed     <= '0;
            s1_flag   <= 1'b0;
            err_cnt   <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else begin
            s1_vld <= 1'b0;

            // Fold the staged sample into the statistics.
            if (s1_vld) begin
                err_cnt <= err_cnt + CNT_W'(s1_flag);
                sum_ed  <= sum_ed + (SUM_W+WIN_LOG2)'(s1_ed);
                if (s1_ed > max_ed) begin
                    max_ed <= s1_ed;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        err_cnt  <= '0;
                        max_ed   <= '0;
                        sum_ed   <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        s1_vld  <= 1'b1;
                        s1_ed   <= ed;
                        s1_flag <= mismatch;
                        cnt     <= cnt + CNT_W'(1);
                        if (cnt == LAST_IDX) begin
                            state    <= ST_DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last s1 entry is accumulated above on this edge.
                    state     <= ST_REPORT;
                    rpt_valid <= 1'b1;
                end
                ST_REPORT: begin
                    if (rpt_ready) begin
                        state     <= ST_IDLE;
                        rpt_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    rpt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
